button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 28 ++
 rtl/button_channel.sv | 132 +++++++++++++
 rtl/button_conditioner.sv | 66 ++++++
 tb/tb_button_conditioner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared debounce FSM state encoding and default timing for the button conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package button_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  // Defaults assume a 50 MHz clk: 10 ms debounce, 500 ms to first repeat, 100 ms repeat period.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // One counter width covers debounce and repeat timing; the largest terminal count is
  // max-1, so $clog2(max) bits always hold it. Width is clamped to 1 for degenerate values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce FSM with hold counter, optional repeat timer (BUTTON_AUTOREPEAT_EN).
// Latency: raw edge sampled at cycle t moves lvl at t+2+DEBOUNCE_CYCLES; *_nxt outputs lead their registers by one cycle.
// Backpressure: none; free-running, every cycle is evaluated.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic other_lvl,
  output logic lvl,
  output logic lvl_nxt,
  output logic rise_nxt,
  output logic rep_nxt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  btn_state_t    state;
  logic [CW-1:0] cnt;
  logic          commit_hi;
  logic          commit_lo;

  // Commit decisions: the counter only ever climbs to DB_LAST, so it can never wrap.
  always_comb begin
    commit_hi = (state == WAIT_HIGH) && s && (cnt == DB_LAST);
    commit_lo = (state == WAIT_LOW) && !s && (cnt == DB_LAST);
    lvl_nxt   = commit_hi | (lvl & ~commit_lo);
    rise_nxt  = commit_hi;
  end

  // Synchronizer plus debounce FSM; lvl is registered alongside state (1 in HIGH/WAIT_LOW).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      lvl   <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      lvl   <= lvl_nxt;
      case (state)
        LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] tmr;
  logic          first;
  logic [CW-1:0] tmr_lim;

  // Repeat fires only from a settled HIGH with the other button up; first gap is the long delay.
  always_comb begin
    tmr_lim = first ? RD_LAST : RP_LAST;
    rep_nxt = (state == HIGH) && !other_lvl && (tmr == tmr_lim);
  end

  // Repeat timer: restarts on commit and whenever the other button is down; holds in WAIT_LOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr   <= '0;
      first <= 1'b1;
    end else if (commit_hi || ((state == HIGH) && other_lvl)) begin
      tmr   <= '0;
      first <= 1'b1;
    end else if (state == HIGH) begin
      if (tmr == tmr_lim) begin
        tmr   <= '0;
        first <= 1'b0;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end
`else
  // No repeat hardware in this build; the cross-channel level is not needed here.
  logic unused_other_lvl;
  assign unused_other_lvl = other_lvl;
  assign rep_nxt = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces up/down pushbuttons into levels and press strobes; auto-repeat under BUTTON_AUTOREPEAT_EN.
// Latency: level and press strobe appear together at t+2+DEBOUNCE_CYCLES after the raw edge sample.
// Backpressure: none; strobes are one-cycle and unacknowledged.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic up_pulse,
  output logic down_pulse
);

  logic up_lvl_nxt, up_rise_nxt, up_rep_nxt;
  logic dn_lvl_nxt, dn_rise_nxt, dn_rep_nxt;

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_up_raw),
    .other_lvl(down),
    .lvl      (up),
    .lvl_nxt  (up_lvl_nxt),
    .rise_nxt (up_rise_nxt),
    .rep_nxt  (up_rep_nxt)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_down_raw),
    .other_lvl(up),
    .lvl      (down),
    .lvl_nxt  (dn_lvl_nxt),
    .rise_nxt (dn_rise_nxt),
    .rep_nxt  (dn_rep_nxt)
  );

  // Strobes are gated by the other channel's next level so they land with the level rise;
  // a simultaneous commit therefore suppresses both.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
    end else begin
      up_pulse   <= (up_rise_nxt | up_rep_nxt) & ~dn_lvl_nxt;
      down_pulse <= (dn_rise_nxt | dn_rep_nxt) & ~up_lvl_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// A raw value driven just after edge k is first sampled at edge k+1 (cycle t); the level moves at t+6.
// Outputs are checked 1 time unit after each rising edge; pulses are tallied on falling edges.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_up_raw;
  logic btn_down_raw;
  logic up;
  logic down;
  logic up_pulse;
  logic down_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int up_pc   = 0;
  int dn_pc   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .up          (up),
    .down        (down),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (up_pulse === 1'b1) up_pc++;
    if (down_pulse === 1'b1) dn_pc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic hold_check(input string tag, input int n, input logic eu, input logic ed);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_up"}, up, eu);
      chk({tag, "_down"}, down, ed);
    end
  endtask

  initial begin
    int dn_base;

    // Reset with both buttons already held: outputs stay 0 throughout reset.
    rst = 1'b1;
    btn_up_raw = 1'b1;
    btn_down_raw = 1'b1;
    tick();
    chk("rst_up", up, 1'b0);
    chk("rst_down", down, 1'b0);
    chk("rst_up_pulse", up_pulse, 1'b0);
    chk("rst_down_pulse", down_pulse, 1'b0);
    tick();
    chk("rst2_up", up, 1'b0);
    chk("rst2_down", down, 1'b0);
    rst = 1'b0;
    hold_check("a_wait", 6, 1'b0, 1'b0);
    tick();
    chk("a_up_rise", up, 1'b1);
    chk("a_down_rise", down, 1'b1);
    chk("a_up_pulse", up_pulse, 1'b0);
    chk("a_down_pulse", down_pulse, 1'b0);

    // Release both: levels fall after full debounce, releases never pulse.
    btn_up_raw = 1'b0;
    btn_down_raw = 1'b0;
    hold_check("b_rel_wait", 6, 1'b1, 1'b1);
    tick();
    chk("b_up_fall", up, 1'b0);
    chk("b_down_fall", down, 1'b0);
    tick(3);
    chk_n("b_up_count", up_pc, 0);
    chk_n("b_down_count", dn_pc, 0);

    // Clean up press, a 1-cycle release glitch, then a real release.
    btn_up_raw = 1'b1;
    hold_check("c_wait", 6, 1'b0, 1'b0);
    tick();
    chk("c_up_rise", up, 1'b1);
    chk("c_up_pulse", up_pulse, 1'b1);
    chk("c_down_pulse", down_pulse, 1'b0);
    btn_up_raw = 1'b0;
    tick();
    chk("c_pulse_one_cycle", up_pulse, 1'b0);
    chk("c_up_held", up, 1'b1);
    btn_up_raw = 1'b1;
    tick();
    chk("c_up_held2", up, 1'b1);
    btn_up_raw = 1'b0;
    hold_check("c_glitch_rel", 6, 1'b1, 1'b0);
    tick();
    chk("c_up_fall", up, 1'b0);
    chk("c_rel_no_pulse", up_pulse, 1'b0);
    tick(3);
    chk_n("c_up_count", up_pc, 1);

    // Bounce: 1,1,0 then held; the qualification restarts from the final edge.
    btn_up_raw = 1'b1;
    tick(2);
    btn_up_raw = 1'b0;
    tick();
    btn_up_raw = 1'b1;
    hold_check("d_bounce_wait", 6, 1'b0, 1'b0);
    tick();
    chk("d_up_rise", up, 1'b1);
    chk("d_up_pulse", up_pulse, 1'b1);
    btn_up_raw = 1'b0;
    tick(10);
    chk("d_up_fall", up, 1'b0);
    chk_n("d_up_count", up_pc, 2);

    // Reset mid WAIT_HIGH: partial count discarded, full latency after release.
    btn_up_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    tick();
    chk("e_rst_up", up, 1'b0);
    rst = 1'b0;
    hold_check("e_requal", 6, 1'b0, 1'b0);
    tick();
    chk("e_up_rise", up, 1'b1);
    chk("e_up_pulse", up_pulse, 1'b1);
    btn_up_raw = 1'b0;
    tick(10);
    chk_n("e_up_count", up_pc, 3);

    // Simultaneous press: both levels rise together, no pulses at all.
    btn_up_raw = 1'b1;
    btn_down_raw = 1'b1;
    hold_check("f_wait", 6, 1'b0, 1'b0);
    tick();
    chk("f_up_rise", up, 1'b1);
    chk("f_down_rise", down, 1'b1);
    chk("f_up_pulse", up_pulse, 1'b0);
    chk("f_down_pulse", down_pulse, 1'b0);
    tick(12);
    chk_n("f_up_count", up_pc, 3);
    chk_n("f_down_count", dn_pc, 0);
    btn_up_raw = 1'b0;
    btn_down_raw = 1'b0;
    tick(10);
    chk("f_up_fall", up, 1'b0);
    chk("f_down_fall", down, 1'b0);

    // Down held first: its press pulses; a later up press raises up but is gated.
    btn_down_raw = 1'b1;
    tick(7);
    chk("h_down_rise", down, 1'b1);
    chk("h_down_pulse", down_pulse, 1'b1);
    btn_up_raw = 1'b1;
    hold_check("h_up_wait", 6, 1'b0, 1'b1);
    tick();
    chk("h_up_rise", up, 1'b1);
    chk("h_both_down", down, 1'b1);
    chk("h_up_gated", up_pulse, 1'b0);
    tick(2);
    chk_n("h_up_count", up_pc, 3);
    btn_up_raw = 1'b0;
    btn_down_raw = 1'b0;
    tick(12);

    // Down held alone: press pulse at C, repeats at C+8, C+11, C+14 when enabled.
    dn_base = dn_pc;
    btn_down_raw = 1'b1;
    hold_check("g_wait", 6, 1'b0, 1'b0);
    tick();
    chk("g_down_rise", down, 1'b1);
    chk("g_down_pulse", down_pulse, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      if (k == 14) btn_down_raw = 1'b0;
      tick();
`ifdef BUTTON_AUTOREPEAT_EN
      chk("g_repeat", down_pulse, logic'((k == 8) || (k == 11) || (k == 14)));
`else
      chk("g_repeat", down_pulse, 1'b0);
`endif
      chk("g_up_quiet", up_pulse, 1'b0);
    end
    chk("g_down_fall", down, 1'b0);
    tick(2);
`ifdef BUTTON_AUTOREPEAT_EN
    chk_n("g_down_count", dn_pc - dn_base, 4);
`else
    chk_n("g_down_count", dn_pc - dn_base, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
